// File: rtl/cdir_scan_controller.sv
// Scan sequencer for sn_cdir_decoder: measures every RO pair in turn, stores the
// per-pair aging delta, tracks max/sum and flags a recycled device at the end.
module cdir_scan_controller #(
   parameter int NO_CDIR      = 8,
   parameter int MUX_SEL_SIZE = 3,
   parameter int RST_CYCLES   = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [31:0]               threshold,
   output logic [1:0]                mode,
   output logic [MUX_SEL_SIZE-1:0]   r_mux_sel,
   output logic [MUX_SEL_SIZE-1:0]   s_mux_sel,
   input  logic [31:0]               r_freq,
   input  logic [31:0]               s_freq,
   input  logic                      ro_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      recycled,
   output logic [31:0]               diff_max,
   output logic [32+MUX_SEL_SIZE-1:0] diff_sum,
   output logic [NO_CDIR-1:0]        neg_mask,
   output logic [NO_CDIR-1:0]        tmo_mask,
   input  logic [MUX_SEL_SIZE-1:0]   rd_idx,
   output logic [31:0]               rd_diff
);

   localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_MEAS = 3'd2,
      S_CAPT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                  state, next_state;
   logic [CW-1:0]           cnt;
   logic [MUX_SEL_SIZE-1:0] idx;
   logic [31:0]             thr_lat;
   logic [31:0]             r_cap, s_cap;
   logic                    tmo_cap;
   logic [31:0]             deltas [NO_CDIR];

   logic                    start_ok, rst_last, meas_hit, meas_tmo, last_idx;
   logic                    neg_now;
   logic [31:0]             delta_now, max_now;

   // Delta is clamped at zero for a timed-out or inverted pair.
   function automatic logic [31:0] calc_delta(input logic [31:0] r, input logic [31:0] s,
                                              input logic tmo);
      if (tmo || (s > r)) begin
         return 32'd0;
      end else begin
         return r - s;
      end
   endfunction

   assign start_ok  = start && !abort;
   assign rst_last  = (cnt == CW'(RST_CYCLES - 1));
   assign meas_hit  = (cnt != '0) && ro_valid;
   assign meas_tmo  = (cnt == CW'(TIMEOUT - 1));
   assign last_idx  = (idx == MUX_SEL_SIZE'(NO_CDIR - 1));
   assign delta_now = calc_delta(r_cap, s_cap, tmo_cap);
   assign neg_now   = !tmo_cap && (s_cap > r_cap);
   assign max_now   = (delta_now > diff_max) ? delta_now : diff_max;
   assign rd_diff   = deltas[rd_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (abort && (state != S_IDLE)) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  next_state = start_ok ? S_RST : S_IDLE;
            S_RST:   next_state = rst_last ? S_MEAS : S_RST;
            S_MEAS:  next_state = (meas_hit || meas_tmo) ? S_CAPT : S_MEAS;
            S_CAPT:  next_state = last_idx ? S_DONE : S_RST;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mode = 2'b01;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_IDLE:  mode = 2'b01;
         S_RST:   begin mode = 2'b00; busy = 1'b1; end
         S_MEAS:  begin mode = 2'b10; busy = 1'b1; end
         S_CAPT:  begin mode = 2'b10; busy = 1'b1; end
         S_DONE:  begin mode = 2'b01; done = 1'b1; end
         default: mode = 2'b01;
      endcase
      r_mux_sel = (state == S_IDLE) ? '0 : idx;
      s_mux_sel = r_mux_sel;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         thr_lat  <= 32'd0;
         r_cap    <= 32'd0;
         s_cap    <= 32'd0;
         tmo_cap  <= 1'b0;
         recycled <= 1'b0;
         diff_max <= 32'd0;
         diff_sum <= '0;
         neg_mask <= '0;
         tmo_mask <= '0;
         for (int i = 0; i < NO_CDIR; i++) begin
            deltas[i] <= 32'd0;
         end
      end else begin
         // Counter restarts on every state change so RST and MEAS each count from zero.
         if ((state == S_IDLE) || (state != next_state)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if ((state == S_IDLE) && start_ok) begin
            thr_lat  <= threshold;
            idx      <= '0;
            recycled <= 1'b0;
            diff_max <= 32'd0;
            diff_sum <= '0;
            neg_mask <= '0;
            tmo_mask <= '0;
         end
         if ((state == S_MEAS) && (next_state == S_CAPT)) begin
            r_cap   <= r_freq;
            s_cap   <= s_freq;
            tmo_cap <= !meas_hit;
         end
         if ((state == S_CAPT) && !abort) begin
            deltas[idx]   <= delta_now;
            diff_max      <= max_now;
            diff_sum      <= diff_sum + {{MUX_SEL_SIZE{1'b0}}, delta_now};
            neg_mask[idx] <= neg_now;
            tmo_mask[idx] <= tmo_cap;
            if (last_idx) begin
               recycled <= (max_now > thr_lat);
            end else begin
               idx <= idx + MUX_SEL_SIZE'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cdir_scan_controller.sv
// Directed + randomized bench for cdir_scan_controller with a behavioural decoder
// and a per-scan reference computed from the pair values.
module tb_cdir_scan_controller;
   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [31:0]   threshold = 32'd0;
   logic [1:0]    mode;
   logic [SW-1:0] r_mux_sel, s_mux_sel;
   logic [31:0]   r_freq = 32'd0, s_freq = 32'd0;
   logic          ro_valid = 1'b0;
   logic          busy, done, recycled;
   logic [31:0]   diff_max;
   logic [34:0]   diff_sum;
   logic [N-1:0]  neg_mask, tmo_mask;
   logic [SW-1:0] rd_idx = '0;
   logic [31:0]   rd_diff;

   int vectors = 0;
   int miscompares = 0;

   // Decoder configuration per pair
   logic [31:0] rv [N];
   logic [31:0] sv [N];
   int          dly [N];
   bit          never [N];

   int mcnt = 0;
   int done_cnt = 0;
   int run = 0, runs = 0, bad_runs = 0;

   cdir_scan_controller #(.NO_CDIR(N), .MUX_SEL_SIZE(SW), .RST_CYCLES(4), .TIMEOUT(1023)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .threshold(threshold),
      .mode(mode), .r_mux_sel(r_mux_sel), .s_mux_sel(s_mux_sel),
      .r_freq(r_freq), .s_freq(s_freq), .ro_valid(ro_valid),
      .busy(busy), .done(done), .recycled(recycled), .diff_max(diff_max),
      .diff_sum(diff_sum), .neg_mask(neg_mask), .tmo_mask(tmo_mask),
      .rd_idx(rd_idx), .rd_diff(rd_diff)
   );

   always #5 clk = ~clk;

   // Behavioural decoder: valid rises dly cycles into measure mode, stays high.
   always @(negedge clk) begin
      if (mode == 2'b10) mcnt = mcnt + 1;
      else mcnt = 0;
      ro_valid = (mcnt >= dly[r_mux_sel]) && !never[r_mux_sel];
      r_freq   = rv[r_mux_sel];
      s_freq   = sv[r_mux_sel];
   end

   // Monitors: done pulses and length of each mode=00 run.
   always @(negedge clk) begin
      if (done) done_cnt = done_cnt + 1;
      if (mode == 2'b00) run = run + 1;
      else if (run != 0) begin
         runs = runs + 1;
         if (run != 4) bad_runs = bad_runs + 1;
         run = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_nominal();
      for (int i = 0; i < N; i++) begin
         rv[i] = 32'h1000 + 32'(i);
         sv[i] = 32'h0F00;
         dly[i] = 100;
         never[i] = 1'b0;
      end
   endtask

   task automatic wait_for(input logic [1:0] m, input int s, input string tag);
      int n = 0;
      while (!(mode == m && r_mux_sel == SW'(s)) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(mode == m && r_mux_sel == SW'(s)), 64'd1);
   endtask

   task automatic run_and_check(input logic [31:0] thr, input string nm);
      logic [31:0] edel [N];
      logic [31:0] emax = 32'd0;
      logic [63:0] esum = 64'd0;
      logic [N-1:0] eneg = '0, etmo = '0;
      int dc0, runs0, bad0, n;
      for (int i = 0; i < N; i++) begin
         if (never[i]) begin
            edel[i] = 32'd0; etmo[i] = 1'b1;
         end else if (sv[i] > rv[i]) begin
            edel[i] = 32'd0; eneg[i] = 1'b1;
         end else begin
            edel[i] = rv[i] - sv[i];
         end
         if (edel[i] > emax) emax = edel[i];
         esum = esum + 64'(edel[i]);
      end
      dc0 = done_cnt; runs0 = runs; bad0 = bad_runs;
      @(negedge clk); start = 1'b1; threshold = thr;
      @(negedge clk); start = 1'b0; threshold = ~thr;
      check({nm, " busy_after_start"}, 64'(busy), 64'd1);
      check({nm, " mode_rst"}, 64'(mode), 64'd0);
      n = 0;
      while (!done && n < 20000) begin @(negedge clk); n++; end
      check({nm, " done_seen"}, 64'(done), 64'd1);
      check({nm, " busy_at_done"}, 64'(busy), 64'd0);
      check({nm, " recycled"}, 64'(recycled), 64'(emax > thr));
      check({nm, " diff_max"}, 64'(diff_max), 64'(emax));
      check({nm, " diff_sum"}, 64'(diff_sum), esum);
      check({nm, " neg_mask"}, 64'(neg_mask), 64'(eneg));
      check({nm, " tmo_mask"}, 64'(tmo_mask), 64'(etmo));
      @(negedge clk);
      check({nm, " done_single"}, 64'(done), 64'd0);
      check({nm, " mode_idle"}, 64'(mode), 64'd1);
      check({nm, " recycled_held"}, 64'(recycled), 64'(emax > thr));
      check({nm, " done_count"}, 64'(done_cnt - dc0), 64'd1);
      check({nm, " rst_runs"}, 64'(runs - runs0), 64'(N));
      check({nm, " rst_run_len"}, 64'(bad_runs - bad0), 64'd0);
      for (int i = 0; i < N; i++) begin
         rd_idx = SW'(i);
         #1;
         check($sformatf("%s rd_diff[%0d]", nm, i), 64'(rd_diff), 64'(edel[i]));
      end
   endtask

   initial begin
      int dc0;
      set_nominal();
      // Reset held for three cycles
      repeat (3) @(negedge clk);
      check("rst mode", 64'(mode), 64'd1);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst recycled", 64'(recycled), 64'd0);
      check("rst diff_max", 64'(diff_max), 64'd0);
      check("rst diff_sum", 64'(diff_sum), 64'd0);
      check("rst masks", 64'({neg_mask, tmo_mask}), 64'd0);
      check("rst sel", 64'({r_mux_sel, s_mux_sel}), 64'd0);
      for (int i = 0; i < N; i++) begin
         rd_idx = SW'(i); #1;
         check($sformatf("rst rd_diff[%0d]", i), 64'(rd_diff), 64'd0);
      end
      rst_n = 1'b1;

      run_and_check(32'h105, "nominal");
      check("nominal sum const", 64'(diff_sum), 64'h81C);
      run_and_check(32'h107, "thr_equal");

      sv[3] = 32'h2000;
      run_and_check(32'h105, "negative");
      check("negative mask const", 64'(neg_mask), 64'h08);

      set_nominal();
      never[5] = 1'b1;
      run_and_check(32'h105, "timeout");
      check("timeout mask const", 64'(tmo_mask), 64'h20);

      // Abort while measuring pair 2
      set_nominal();
      dc0 = done_cnt;
      @(negedge clk); start = 1'b1; threshold = 32'h0;
      @(negedge clk); start = 1'b0;
      wait_for(2'b10, 2, "abort reach_meas2");
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort mode", 64'(mode), 64'd1);
      check("abort busy", 64'(busy), 64'd0);
      check("abort sel", 64'(r_mux_sel), 64'd0);
      check("abort recycled", 64'(recycled), 64'd0);
      rd_idx = SW'(1); #1;
      check("abort partial rd_diff[1]", 64'(rd_diff), 64'h101);
      repeat (20) @(negedge clk);
      check("abort no_done", 64'(done_cnt - dc0), 64'd0);
      check("abort still_idle", 64'(mode), 64'd1);
      // Start coincident with abort is ignored
      start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("start_abort ignored", 64'(busy), 64'd0);
      run_and_check(32'h105, "after_abort");

      // Reset while resetting pair 4
      @(negedge clk); start = 1'b1; threshold = 32'h0;
      @(negedge clk); start = 1'b0;
      wait_for(2'b00, 4, "reset reach_rst4");
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst mode", 64'(mode), 64'd1);
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      check("midrst recycled", 64'(recycled), 64'd0);
      check("midrst diff_max", 64'(diff_max), 64'd0);
      check("midrst diff_sum", 64'(diff_sum), 64'd0);
      check("midrst masks", 64'({neg_mask, tmo_mask}), 64'd0);
      for (int i = 0; i < N; i++) begin
         rd_idx = SW'(i); #1;
         check($sformatf("midrst rd_diff[%0d]", i), 64'(rd_diff), 64'd0);
      end

      // Randomized scans
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) begin
            rv[i] = $urandom;
            sv[i] = ($urandom_range(0, 3) == 0) ? $urandom : rv[i] - ($urandom & 32'hFFFF);
            dly[i] = $urandom_range(1, 60);
            never[i] = ($urandom_range(0, 9) == 0);
         end
         run_and_check((k == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h1FFFF), $sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cdir_scan_controller.md
Name: cdir_scan_controller

Overview:
- Sequencer that owns the mode and mux-select inputs of sn_cdir_decoder and scans all NO_CDIR RO pairs after a single start pulse.
- For each pair index i, it resets the decoder, runs a measurement window and captures r_freq/s_freq on valid.
- It computes the aging delta r_freq - s_freq, stores it per index, and accumulates max and sum.
- When the scan finishes it flags the device as recycled if the max delta exceeds a threshold. Sits between the security-engine CSR/FSM layer and sn_cdir_decoder.

Parameters:
- NO_CDIR, 8, number of RO pairs scanned.
- MUX_SEL_SIZE, 3, log2(NO_CDIR); width of index and mux selects.
- RST_CYCLES, 4, cycles mode=00 is held before each measurement (>=1).
- TIMEOUT, 1023, maximum cycles spent in MEAS waiting for valid.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a scan; ignored while busy.
- abort  in  1  returns to IDLE at the next edge; results are not updated.
- threshold  in  32  recycle threshold; sampled on accepted start.
- mode  out  2  to decoder: 00 reset, 01 stress/idle, 10 measure.
- r_mux_sel  out  MUX_SEL_SIZE  reference RO select.
- s_mux_sel  out  MUX_SEL_SIZE  stressed RO select.
- r_freq  in  32  decoder reference count.
- s_freq  in  32  decoder stressed count.
- ro_valid  in  1  decoder valid_out.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at scan completion.
- recycled  out  1  diff_max > threshold; valid after done, held until next start.
- diff_max  out  32  largest per-index delta of the last scan.
- diff_sum  out  32+MUX_SEL_SIZE  sum of deltas of the last scan.
- neg_mask  out  NO_CDIR  bit i set when s_freq > r_freq at index i.
- tmo_mask  out  NO_CDIR  bit i set when index i timed out.
- rd_idx  in  MUX_SEL_SIZE  readback index.
- rd_diff  out  32  stored delta for rd_idx; combinational read of the register file.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE; mode=01; mux selects=0; idx=0.
  - busy=0, done=0, recycled=0.
  - diff_max=0, diff_sum=0, neg_mask=0, tmo_mask=0, all stored deltas=0.
  - A reset mid-scan discards everything; there is no partial completion.
- FSM states:
  - IDLE (mode=01): on start, latch threshold, clear the accumulators, masks and recycled, set idx=0 -> RST.
  - RST (mode=00): hold RST_CYCLES cycles -> MEAS.
  - MEAS (mode=10): the first MEAS cycle is a blanking cycle and ro_valid is ignored. From the 2nd cycle, ro_valid=1 -> CAPT. A cycle counter reaching TIMEOUT without valid -> CAPT with the timeout flag set.
  - CAPT (mode=10):
    - Compute delta = r_freq - s_freq if r_freq >= s_freq; else delta=0 and set neg_mask[idx]. On timeout, delta=0 and set tmo_mask[idx].
    - Write delta[idx]; diff_max = max(diff_max, delta); diff_sum += delta (no overflow possible at this width).
    - If idx==NO_CDIR-1 -> DONE; else idx+1 -> RST.
  - DONE (mode=01): recycled = (diff_max > latched threshold); done=1 for one cycle; busy=0 -> IDLE.
- Mux selects: r_mux_sel = s_mux_sel = idx in every state except IDLE, where both are 0.
- Capture: r_freq/s_freq are sampled on the same edge that sees ro_valid=1 in MEAS; the result registers update in CAPT.
- Busy: start while busy is ignored; start coincident with abort is ignored.
- Abort: from any non-IDLE state, go to IDLE (mode=01) next edge with busy=0 and done not pulsed. Partial deltas already written remain readable, but recycled stays 0.
- Comparison: recycled uses strict > with threshold; diff == threshold gives recycled=0.
- Latency: one index takes RST_CYCLES + 1 + (valid wait) + 1 cycles.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> mode=01, busy=0, done=0, diff_max=0, all masks 0, rd_diff=0 for every rd_idx.
- Nominal scan: decoder model returns r_freq=0x1000+i, s_freq=0x0F00, valid 100 cycles after mode=10; threshold=0x105.
  - Mode sequence per index: 00 for 4 cycles, then 10.
  - rd_diff[i] = 0x100+i; diff_max=0x107; diff_sum=0x81C; recycled=1; done is a single pulse.
- Threshold boundary: same stimulus with threshold=0x107 -> recycled=0.
- Negative delta: index 3 returns s_freq=0x2000 > r_freq -> neg_mask=0x08, rd_diff[3]=0, the scan completes normally.
- Timeout: index 5 never asserts valid -> MEAS exits after TIMEOUT cycles, tmo_mask=0x20, rd_diff[5]=0, the scan continues to index 7.
- Abort/reset mid-scan: abort during MEAS at idx=2 -> IDLE next edge, mode=01, no done. Then start again -> full scan with correct results. rst_n=0 during RST at idx=4 -> all outputs at reset values.
